// File: rtl/system_bus_pkg.sv
// Shared system-bus definitions: bus widths and the responder state encoding.
// Contents: SYSTEM_BUS_ADDR_W / SYSTEM_BUS_DATA_W / SYSTEM_BUS_BE_W, system_bus_ram_state_t.
package system_bus_pkg;

    localparam int unsigned SYSTEM_BUS_ADDR_W = 32;
    localparam int unsigned SYSTEM_BUS_DATA_W = 32;
    localparam int unsigned SYSTEM_BUS_BE_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } system_bus_ram_state_t;

endpackage

// File: rtl/byte_enable_ram.sv
// Single-port word RAM with per-byte-lane write enables and a registered read.
// No reset on the array or read register so the storage maps onto block RAM.
// Ports:
//   clk       in   clock
//   i_lane_we in   per-lane write enables (bit i -> data[8i+7:8i])
//   i_rd_en   in   capture mem[i_addr] into o_rdata at this edge
//   i_addr    in   word address
//   i_wdata   in   write data
//   o_rdata   out  registered read data (holds when i_rd_en is low)
module byte_enable_ram
    import system_bus_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic                         clk,
    input  logic [SYSTEM_BUS_BE_W-1:0]   i_lane_we,
    input  logic                         i_rd_en,
    input  logic [ADDR_BITS-1:0]         i_addr,
    input  logic [SYSTEM_BUS_DATA_W-1:0] i_wdata,
    output logic [SYSTEM_BUS_DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [SYSTEM_BUS_DATA_W-1:0] r_mem [DEPTH];

    // Byte-lane writes plus enabled registered read.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < SYSTEM_BUS_BE_W; i++) begin
            if (i_lane_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        if (i_rd_en) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/system_bus_ram.sv
// System-bus responder RAM: accepts byte-lane writes and full-word reads,
// inserts WAIT_STATES idle cycles after every accepted request, and returns
// read data READ_LATENCY cycles after acceptance through a valid pipeline.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   system_bus_ready            out  request accepted this cycle if req is high
//   system_bus_addr             in   byte address (word index = addr[ADDR_BITS+1:2])
//   system_bus_write_data       in   write data
//   system_bus_byte_enable      in   write lane enables
//   system_bus_write_req        in   write request (wins over a simultaneous read)
//   system_bus_read_req         in   read request
//   system_bus_read_data        out  read data, held between strobes
//   system_bus_read_data_valid  out  one-cycle strobe qualifying read data
module system_bus_ram
    import system_bus_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 12,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned WAIT_STATES  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         system_bus_ready,
    input  logic [SYSTEM_BUS_ADDR_W-1:0] system_bus_addr,
    input  logic [SYSTEM_BUS_DATA_W-1:0] system_bus_write_data,
    input  logic [SYSTEM_BUS_BE_W-1:0]   system_bus_byte_enable,
    input  logic                         system_bus_write_req,
    input  logic                         system_bus_read_req,
    output logic [SYSTEM_BUS_DATA_W-1:0] system_bus_read_data,
    output logic                         system_bus_read_data_valid
);

    localparam int unsigned WAIT_W = 2;

    if (READ_LATENCY == 0 || READ_LATENCY > 4) begin : g_bad_read_latency
        $fatal(1, "system_bus_ram: READ_LATENCY must be in 1..4");
    end
    if (WAIT_STATES > 3) begin : g_bad_wait_states
        $fatal(1, "system_bus_ram: WAIT_STATES must be in 0..3");
    end

    system_bus_ram_state_t          r_state;
    system_bus_ram_state_t          w_state_nxt;
    logic [WAIT_W-1:0]              r_wait_cnt;
    logic [WAIT_W-1:0]              w_wait_cnt_nxt;
    logic                           r_ready;
    logic                           w_accept;
    logic                           w_wr_accept;
    logic                           w_rd_accept;
    logic [SYSTEM_BUS_BE_W-1:0]     w_lane_we;
    logic [SYSTEM_BUS_DATA_W-1:0]   w_ram_q;
    logic                           w_unused_addr;

    assign system_bus_ready = r_ready;

    // A simultaneous read+write is a write only.
    assign w_accept    = r_ready & (system_bus_read_req | system_bus_write_req);
    assign w_wr_accept = r_ready & system_bus_write_req;
    assign w_rd_accept = r_ready & system_bus_read_req & ~system_bus_write_req;
    assign w_lane_we   = w_wr_accept ? system_bus_byte_enable : '0;

    // Byte offset and high address bits are ignored, so memory aliases.
    assign w_unused_addr = ^{system_bus_addr[SYSTEM_BUS_ADDR_W-1:ADDR_BITS+2],
                             system_bus_addr[1:0]};

    // Wait-state FSM next-state logic.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept && (WAIT_STATES != 0)) begin
                    w_state_nxt    = WAIT;
                    w_wait_cnt_nxt = WAIT_W'(WAIT_STATES);
                end
            end
            WAIT: begin
                if (r_wait_cnt <= WAIT_W'(1)) begin
                    w_state_nxt    = IDLE;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - WAIT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // State register; ready is registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_ready    <= (w_state_nxt == IDLE);
        end
    end

    byte_enable_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk       (clk),
        .i_lane_we (w_lane_we),
        .i_rd_en   (w_rd_accept),
        .i_addr    (system_bus_addr[ADDR_BITS+1:2]),
        .i_wdata   (system_bus_write_data),
        .o_rdata   (w_ram_q)
    );

    if (READ_LATENCY == 1) begin : g_lat1
        logic r_vld;
        logic r_seen;

        // RAM register is the output stage; masked to zero until the first read after reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld  <= 1'b0;
                r_seen <= 1'b0;
            end else begin
                r_vld  <= w_rd_accept;
                r_seen <= r_seen | w_rd_accept;
            end
        end

        assign system_bus_read_data_valid = r_vld;
        assign system_bus_read_data       = r_seen ? w_ram_q : '0;
    end else begin : g_latn
        logic [READ_LATENCY-1:0]      r_vld;
        logic [SYSTEM_BUS_DATA_W-1:0] r_data [READ_LATENCY-1];

        // r_data[k] pairs with r_vld[k+1]; stages load only when data arrives so output holds.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld <= '0;
                for (int unsigned k = 0; k < READ_LATENCY - 1; k++) begin
                    r_data[k] <= '0;
                end
            end else begin
                r_vld <= {r_vld[READ_LATENCY-2:0], w_rd_accept};
                if (r_vld[0]) begin
                    r_data[0] <= w_ram_q;
                end
                for (int unsigned k = 1; k < READ_LATENCY - 1; k++) begin
                    if (r_vld[k]) begin
                        r_data[k] <= r_data[k-1];
                    end
                end
            end
        end

        assign system_bus_read_data_valid = r_vld[READ_LATENCY-1];
        assign system_bus_read_data       = r_data[READ_LATENCY-2];
    end

endmodule

// File: doc/system_bus_ram.md
# system_bus_ram

Single-port RAM that acts as the responder end of the system bus: it accepts read and write requests from a bus initiator such as the CPU fetch/load-store path. Writes use byte lanes. Reads return data after a fixed, parameterised latency through a valid pipeline. A wait-state counter models slower memories by deasserting `system_bus_ready` after each accepted request. The block sits behind the bus interconnect and serves as program/data memory for simulation and FPGA builds.

## Interface
- `ADDR_BITS`, default 12: word-address width; capacity is 2^ADDR_BITS 32-bit words.
- `READ_LATENCY`, default 2: cycles from the read-acceptance edge to `read_data_valid`. Legal range 1..4.
- `WAIT_STATES`, default 0: cycles `ready` stays low after any accepted request. Legal range 0..3.

- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `system_bus_ready`  out  1  responder can accept a request this cycle.
- `system_bus_addr`  in  32  byte address.
- `system_bus_write_data`  in  32  write data.
- `system_bus_byte_enable`  in  4  lane enables; bit i covers data[8i+7:8i].
- `system_bus_write_req`  in  1  write request.
- `system_bus_read_req`  in  1  read request.
- `system_bus_read_data`  out  32  read data.
- `system_bus_read_data_valid`  out  1  one-cycle strobe qualifying `read_data`.

## Operation
- **Acceptance:** a request is accepted on the edge where `ready` and (`read_req` or `write_req`) are both 1. If `ready` is 0, requests are ignored. The initiator must hold its request until it is accepted.
- **Word index:** `addr[ADDR_BITS+1:2]`. `addr[1:0]` and the upper address bits are ignored, so the memory aliases across the address space.
- **Write:** on acceptance, the RAM updates only the bytes whose lane in `byte_enable` is 1. `byte_enable` = 0 is a legal no-op write that still consumes any wait states.
- **Read:** `byte_enable` is ignored and the full word is always returned.
- **Simultaneous read and write:** if `read_req` and `write_req` are both 1 in the same cycle, the request is treated as a write only. No read data is returned.
- **State machine, IDLE:** `ready`=1.
  - Acceptance with `WAIT_STATES`=0: stay in IDLE.
  - Acceptance with `WAIT_STATES`>0: load the counter with `WAIT_STATES` and go to WAIT.
- **State machine, WAIT:** `ready`=0. The counter decrements each cycle. When it reaches 1, return to IDLE.
- **Read pipeline:** a valid shift register of length `READ_LATENCY` carries each accepted read. The RAM read is registered; any extra stages delay both data and valid together.
- **Ordering:** reads complete strictly in acceptance order.
- **Read after write:** a write accepted at edge N is visible to a read accepted at edge N+1 or later. The same-edge case cannot occur.

## Timing
- **Reset values:** `ready`=0, `read_data_valid`=0, `read_data`=0. State is IDLE, the counter is 0 and every pipeline valid bit is 0.
- **Reset mid-operation:** in-flight reads are discarded; no `read_data_valid` pulse appears after reset is released. RAM contents are not reset.
- **Ready after reset:** `ready` rises at the first edge where `reset` is low.
- **Read latency:** read accepted at edge N gives `read_data_valid`=1 for exactly the cycle after edge N+`READ_LATENCY`-1, i.e. visible `READ_LATENCY` cycles after acceptance.
- **Throughput:** one request per cycle when `WAIT_STATES`=0; otherwise one request per `WAIT_STATES`+1 cycles.
- **Wait states and reads:** `WAIT_STATES` does not stretch read latency. The valid pipeline advances during WAIT.
- **Read data between strobes:** `read_data` holds its last value whenever `read_data_valid`=0.

## Structure
- **Package `system_bus_pkg`:** bus width constants (addr 32, data 32, byte-enable 4) and the `system_bus_ram_state_t` enum {IDLE, WAIT}. The package is shared with other bus responders.
- **Sub-module `byte_enable_ram`:**
  - parameter `ADDR_BITS`;
  - per-lane write enables;
  - one-cycle registered read;
  - no reset, so it infers block RAM.
- **Top level:** acceptance logic, wait counter, valid/data delay stages, and `READ_LATENCY`/`WAIT_STATES` range assertions.

## Test plan
- **Reset:** hold `reset` high for 3 cycles with `read_req`=1 → `ready`=0 and `read_data_valid`=0 throughout; `ready`=1 one edge after release.
- **Write then read (defaults):** write 0xDEADBEEF to 0x10 with `byte_enable`=0xF, then read 0x10 on the next cycle → `read_data_valid` 2 cycles after the read is accepted, with `read_data`=0xDEADBEEF.
- **Byte lanes:** write 0x11223344 with `byte_enable`=0b0101 over prior contents 0xAABBCCDD → subsequent read returns 0xAA22CC44.
- **Back-to-back reads:** reads to words 0,1,2,3 on consecutive cycles → four consecutive valid strobes with data in order and `ready` never low.
- **Wait states:** with `WAIT_STATES`=2, `READ_LATENCY`=3, a read at edge N → `ready`=0 for two cycles, high again after edge N+2, and valid visible 3 cycles after N. With both req lines high → memory is written and no valid pulse appears.
- **Reset mid-read and aliasing:** assert `reset` one cycle after a read is accepted → no valid pulse ever appears. With `ADDR_BITS`=12, address 0x4010 aliases 0x0010 → reads of either return the same data.
